// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART TX FIFO write port
// among NREQ byte requesters.
//
// Build option: define UART_ARB_PACKET_LOCK_EN to hold a grant until the
// requester's req_last byte is accepted. Without it, a grant ends when the
// holder drops valid or after MAXBURST bytes.
//
// state | meaning
// IDLE  | no grant held, choosing next requester from rrPtr upward
// XFER  | grantId owns the FIFO write port, bytes pass through combinationally
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAXBURST = 8,
  localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              abort,
  input  logic              fifo_full,
  output logic              fifo_wen,
  output logic [7:0]        fifo_wdata,
  output logic [GW-1:0]     grant_id,
  output logic              busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        stateQ, stateD;
  logic [GW-1:0] rrPtr, rrPtrD;
  logic [GW-1:0] grantId, grantIdD;
  logic [7:0]    beatCnt, beatCntD;

  logic          pickValid;
  logic [GW-1:0] pickIdx;
  logic          grantValid;
  logic [7:0]    grantData;
  logic          accept;
  logic [7:0]    beatInc;
  logic          releaseNow;
  logic [GW-1:0] grantIdInc;

  // Round-robin search: first valid requester at or above rrPtr, wrapping.
  always_comb begin
    int idx;
    pickValid = 1'b0;
    pickIdx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rrPtr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pickValid && req_valid[idx]) begin
        pickValid = 1'b1;
        pickIdx   = GW'(idx);
      end
    end
  end

  assign grantValid = req_valid[grantId];
  assign grantData  = req_data[int'(grantId)*8 +: 8];
  assign accept     = (stateQ == XFER) && grantValid && !fifo_full;
  assign beatInc    = beatCnt + 8'd1;
  assign grantIdInc = (int'(grantId) == NREQ-1) ? '0 : grantId + GW'(1);

`ifdef UART_ARB_PACKET_LOCK_EN
  logic grantLast;
  assign grantLast  = req_last[grantId];
  // Valid gaps keep the grant; only the end of packet or an abort frees it.
  assign releaseNow = abort || (accept && grantLast);
`else
  logic unusedLast;
  assign unusedLast = ^req_last;
  // Free the port when the holder goes quiet or has used its burst allowance.
  assign releaseNow = abort || !grantValid || (accept && (beatInc == 8'(MAXBURST)));
`endif

  // Only the grant holder sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (stateQ == XFER) req_ready[grantId] = !fifo_full;
  end

  assign fifo_wen   = accept;
  assign fifo_wdata = accept ? grantData : 8'h00;
  assign grant_id   = grantId;
  assign busy       = (stateQ == XFER);

  // Next-state logic for the FSM and its grant bookkeeping.
  always_comb begin
    stateD   = stateQ;
    rrPtrD   = rrPtr;
    grantIdD = grantId;
    beatCntD = beatCnt;
    case (stateQ)
      IDLE: begin
        if (pickValid) begin
          grantIdD = pickIdx;
          beatCntD = 8'd0;
          stateD   = XFER;
        end
      end
      XFER: begin
        if (accept) beatCntD = beatInc;
        if (releaseNow) begin
          rrPtrD = grantIdInc;
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State and grant registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      stateQ  <= IDLE;
      rrPtr   <= '0;
      grantId <= '0;
      beatCnt <= 8'd0;
    end else begin
      stateQ  <= stateD;
      rrPtr   <= rrPtrD;
      grantId <= grantIdD;
      beatCnt <= beatCntD;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (default NREQ=4, MAXBURST=8).
// Expected FIFO writes are queued as {grant, byte} when stimulus is issued;
// a monitor pops and compares on every fifo_wen.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              nReset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              abort;
  logic              fifo_full;
  logic              fifo_wen;
  logic [7:0]        fifo_wdata;
  logic [1:0]        grant_id;
  logic              busy;

  logic [7:0] reqQ  [NREQ][$];
  logic       lastQ [NREQ][$];
  logic [9:0] expQ[$];
  int checks = 0;
  int passes = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .MAXBURST(8)) dut (
    .clk(clk), .nReset(nReset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .abort(abort),
    .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
    .grant_id(grant_id), .busy(busy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic pushBytes(int r, int n, logic [7:0] base, logic lastOn);
    for (int k = 0; k < n; k++) begin
      reqQ[r].push_back(base + 8'(k));
      lastQ[r].push_back(lastOn && (k == n-1));
    end
  endtask

  task automatic expectBytes(int g, int n, logic [7:0] base);
    for (int k = 0; k < n; k++) expQ.push_back({2'(g), base + 8'(k)});
  endtask

  function automatic bit allEmpty();
    bit e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (reqQ[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic waitDrain(string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      done = (expQ.size() == 0) && !busy && allEmpty();
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_drain: timeout with %0d writes outstanding, want 0", name, expQ.size());
    end
  endtask

  task automatic waitGrant(string name, int g);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      got = busy && (int'(grant_id) == g);
    end
    if (!got) begin
      checks++;
      $display("FAIL %s_grant: timeout, grant_id %0d busy %0d want grant %0d", name, grant_id, busy, g);
    end
  endtask

  // Monitor: every FIFO write must match the head of the expected queue.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (fifo_wen) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got grant %0d byte 0x%0h want no write", grant_id, fifo_wdata);
        end else begin
          e = expQ.pop_front();
          check("wr_grant", int'(grant_id), int'(e[9:8]));
          check("wr_byte", int'(fifo_wdata), int'(e[7:0]));
        end
      end
    end
  end

  // Requester models: present queue heads, retire a byte after each accept.
  initial begin
    logic [NREQ-1:0] acc;
    logic [7:0] dropB;
    logic       dropL;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && reqQ[i].size() > 0) begin
          dropB = reqQ[i].pop_front();
          dropL = lastQ[i].pop_front();
        end
        if (reqQ[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = reqQ[i][0];
          req_last[i]        = lastQ[i][0];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset    = 1'b0;
    abort     = 1'b0;
    fifo_full = 1'b0;

    // Reset state, with requests already pending
    pushBytes(0, 3, 8'h10, 1'b1);
    pushBytes(2, 3, 8'h20, 1'b1);
    expectBytes(0, 3, 8'h10);
    expectBytes(2, 3, 8'h20);
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_grant", int'(grant_id), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_wen", int'(fifo_wen), 0);
    check("rst_wdata", int'(fifo_wdata), 0);
    nReset = 1'b1;
    waitDrain("two_req");

    // rr_ptr should now be 3: req3 wins over req0
    pushBytes(0, 1, 8'h01, 1'b1);
    pushBytes(3, 1, 8'h30, 1'b1);
    expectBytes(3, 1, 8'h30);
    expectBytes(0, 1, 8'h01);
    waitDrain("rr_probe");

    // Long stream from req1 with req3 pending (rr_ptr = 1)
    pushBytes(1, 20, 8'h40, 1'b1);
    pushBytes(3, 2, 8'h60, 1'b1);
`ifdef UART_ARB_PACKET_LOCK_EN
    expectBytes(1, 20, 8'h40);
    expectBytes(3, 2, 8'h60);
`else
    expectBytes(1, 8, 8'h40);
    expectBytes(3, 2, 8'h60);
    expectBytes(1, 8, 8'h48);
    expectBytes(1, 4, 8'h50);
`endif
    waitDrain("burst");

    // FIFO full for 5 cycles mid-burst
    pushBytes(2, 6, 8'h80, 1'b1);
    expectBytes(2, 6, 8'h80);
    waitGrant("full", 2);
    @(posedge clk);
    #1 fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("full_ready", int'(req_ready), 0);
      check("full_wen", int'(fifo_wen), 0);
      check("full_busy", int'(busy), 1);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    waitDrain("full");

    // Valid gap on req0 with req1 pending (rr_ptr = 3)
    pushBytes(0, 2, 8'hC0, 1'b0);
    pushBytes(1, 1, 8'hD0, 1'b1);
`ifdef UART_ARB_PACKET_LOCK_EN
    expectBytes(0, 4, 8'hC0);
    expectBytes(1, 1, 8'hD0);
`else
    expectBytes(0, 2, 8'hC0);
    expectBytes(1, 1, 8'hD0);
    expectBytes(0, 2, 8'hC2);
`endif
    begin
      int n = 0;
      while (reqQ[0].size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
`ifdef UART_ARB_PACKET_LOCK_EN
      check("gap_busy", int'(busy), 1);
      check("gap_grant", int'(grant_id), 0);
`endif
    end
    pushBytes(0, 2, 8'hC2, 1'b1);
    waitDrain("gap");

    // Abort during req2's first accept; req3 queued behind it
    pushBytes(2, 2, 8'hA5, 1'b1);
    expectBytes(2, 1, 8'hA5);
    expectBytes(3, 1, 8'hB3);
    expectBytes(2, 1, 8'hA6);
    waitGrant("abort", 2);
    abort = 1'b1;
    pushBytes(3, 1, 8'hB3, 1'b1);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_idle", int'(busy), 0);
    waitDrain("abort");

    // Abort while idle must not block a later grant
    abort = 1'b1;
    pushBytes(1, 1, 8'h77, 1'b1);
    expectBytes(1, 1, 8'h77);
    waitGrant("idle_abort", 1);
    abort = 1'b0;
    waitDrain("idle_abort");

    // Reset mid-XFER
    pushBytes(1, 5, 8'hE0, 1'b1);
    expectBytes(1, 1, 8'hE0);
    waitGrant("reset", 1);
    #2 nReset = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(req_ready), 0);
    check("midrst_wen", int'(fifo_wen), 0);
    check("midrst_wdata", int'(fifo_wdata), 0);
    check("midrst_grant", int'(grant_id), 0);
    reqQ[1].delete();
    lastQ[1].delete();
    repeat (3) @(negedge clk);
    nReset = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_grant", int'(grant_id), 0);
    check("postrst_busy", int'(busy), 0);
    check("exp_queue_empty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of byte requesters sharing the UART TX FIFO write port (2..8).
REQ-002 The block SHALL have parameter MAXBURST, default 8, meaning the maximum number of bytes accepted per grant when locking is compiled out (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the system clock with all logic on its rising edge.
REQ-004 The block SHALL have port nReset, input, 1 bit, meaning an asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits, meaning per-requester byte valid.
REQ-006 The block SHALL have port req_data, input, NREQ*8 bits, meaning per-requester byte, with requester i at bits [8i+7:8i].
REQ-007 The block SHALL have port req_last, input, NREQ bits, meaning the current byte is the final byte of the requester's packet.
REQ-008 The block SHALL have port req_ready, output, NREQ bits, meaning per-requester byte accepted this cycle when ANDed with req_valid.
REQ-009 The block SHALL have port abort, input, 1 bit, meaning a synchronous request to drop the current grant.
REQ-010 The block SHALL have port fifo_full, input, 1 bit, meaning the TX FIFO is full.
REQ-011 The block SHALL have port fifo_wen, output, 1 bit, meaning the TX FIFO write enable.
REQ-012 The block SHALL have port fifo_wdata, output, 8 bits, meaning the TX FIFO write data.
REQ-013 The block SHALL have port grant_id, output, clog2(NREQ) bits, meaning the index of the current grant holder.
REQ-014 The block SHALL have port busy, output, 1 bit, meaning the block is in state XFER.

Function
REQ-015 The block SHALL implement states IDLE and XFER.
REQ-016 In IDLE, all req_ready bits SHALL be 0 and fifo_wen SHALL be 0.
REQ-017 In IDLE with any req_valid set, the block SHALL pick the first set bit searching upward from rr_ptr with modulo-NREQ wrap, register it as grant_id, clear beat_cnt, and enter XFER next cycle (1 cycle arbitration latency).
REQ-018 In XFER, req_ready[grant_id] SHALL equal !fifo_full and all other req_ready bits SHALL be 0.
REQ-019 An accept is req_valid[grant_id] && req_ready[grant_id]; on an accept, fifo_wen SHALL be 1 and fifo_wdata SHALL equal the granted byte, both combinationally in the same cycle.
REQ-020 Outside an accept, fifo_wen SHALL be 0 and fifo_wdata SHALL be 8'h00.
REQ-021 beat_cnt (8-bit) SHALL increment on each accept.
REQ-022 On release, the block SHALL set rr_ptr to (grant_id+1) mod NREQ and enter IDLE next cycle.
REQ-023 abort in XFER SHALL force release that cycle; the same-cycle accept SHALL still complete.
REQ-024 abort in IDLE SHALL have no effect.
REQ-025 When fifo_full is held, the block SHALL stay in XFER with no accept and no beat_cnt change.
REQ-026 A requester dropping req_valid while not granted SHALL NOT affect rr_ptr.

Reset
REQ-027 While nReset is low, state SHALL be IDLE, rr_ptr 0, grant_id 0, beat_cnt 0, busy 0, req_ready all 0, fifo_wen 0, fifo_wdata 8'h00.
REQ-028 Reset asserted mid-XFER SHALL abandon the packet with no further FIFO write.

Configuration
REQ-029 Macro UART_ARB_PACKET_LOCK_EN SHALL select packet locking.
REQ-030 With UART_ARB_PACKET_LOCK_EN undefined, release SHALL occur when req_valid[grant_id] is 0 in XFER, or on the accept that brings beat_cnt to MAXBURST, or on abort; req_last SHALL be ignored.
REQ-031 With UART_ARB_PACKET_LOCK_EN defined, release SHALL occur only on an accept with req_last[grant_id]=1, or on abort; valid gaps SHALL hold the grant and MAXBURST SHALL be ignored.

Verification
REQ-032 Requesters 0 and 2 each valid with 3 bytes, lock off, MAXBURST=8 -> FIFO receives req0's 3 bytes, then req2's 3 bytes; rr_ptr=3 after.
REQ-033 Req1 streams 20 bytes, lock off, MAXBURST=8 -> released after 8 bytes; req3 (pending) granted next; req1 resumes afterward.
REQ-034 fifo_full held 5 cycles mid-burst -> req_ready 0 and fifo_wen 0 for those 5 cycles; byte order preserved.
REQ-035 Lock on, req0 sends 4 bytes with a 3-cycle valid gap after byte 2, req1 pending -> req1 not granted until byte 4 with req_last is accepted.
REQ-036 abort pulsed during req2's grant while req2 byte 8'hA5 accepted -> 8'hA5 written; IDLE next cycle; rr_ptr=3.
REQ-037 nReset pulsed low mid-XFER -> all outputs at reset values immediately; grant_id 0 after release.
